// File: rtl/cache_pkg.sv
// Shared definitions for the associative data array: parameter defaults,
// the refill FSM state encoding and the word-address field types.
package cache_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_WORDS_PER_LINE = 16;
    localparam int unsigned DEF_NUM_SETS       = 128;
    localparam int unsigned DEF_NUM_WAYS       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // Select width for n entries, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_WAY_W  = sel_width(DEF_NUM_WAYS);
    localparam int unsigned DEF_IDX_W  = sel_width(DEF_NUM_SETS);
    localparam int unsigned DEF_WORD_W = sel_width(DEF_WORDS_PER_LINE);

    typedef logic [DEF_WAY_W-1:0]  way_sel_t;
    typedef logic [DEF_IDX_W-1:0]  set_idx_t;
    typedef logic [DEF_WORD_W-1:0] word_sel_t;

    typedef struct packed {
        way_sel_t  way;
        set_idx_t  index;
        word_sel_t word;
    } word_addr_t;

endpackage

// File: rtl/way_bank.sv
// One cache way: NUM_SETS x WORDS_PER_LINE words with a byte-strobed write
// port and a registered read word that only updates on CPU accesses.
module way_bank
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned NUM_SETS       = DEF_NUM_SETS,
    localparam int unsigned IDX_W         = sel_width(NUM_SETS),
    localparam int unsigned WORD_W        = sel_width(WORDS_PER_LINE),
    localparam int unsigned NB            = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic                  capture,
    input  logic [IDX_W-1:0]      index,
    input  logic [WORD_W-1:0]     word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NB-1:0]         wstrb,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_SETS][WORDS_PER_LINE];
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] merged;

    // Read-modify-write merge of the strobed bytes into the stored word.
    always_comb begin
        cur    = mem[index][word];
        merged = cur;
        for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) mem[index][word] <= merged;
    end

    // Writes return the post-merge word, reads the stored word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && capture) begin
            rdata <= we ? merged : cur;
        end
    end

endmodule

// File: rtl/assoc_data_array.sv
// Set-associative cache data array: single-word CPU read/write port with
// one-cycle response, plus a beat-by-beat line refill port.
module assoc_data_array
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned NUM_SETS       = DEF_NUM_SETS,
    parameter int unsigned NUM_WAYS       = DEF_NUM_WAYS,
    localparam int unsigned WAY_W         = sel_width(NUM_WAYS),
    localparam int unsigned IDX_W         = sel_width(NUM_SETS),
    localparam int unsigned WORD_W        = sel_width(WORDS_PER_LINE),
    localparam int unsigned NB            = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [WAY_W-1:0]      req_way,
    input  logic [IDX_W-1:0]      req_index,
    input  logic [WORD_W-1:0]     req_word,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NB-1:0]         req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  fill_start,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic [IDX_W-1:0]      fill_index,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_busy,
    output logic                  fill_done
);

    fill_state_e           state_q;
    logic [WORD_W-1:0]     beat_q;
    logic [WAY_W-1:0]      fway_q;
    logic [IDX_W-1:0]      fidx_q;
    logic [WAY_W-1:0]      sel_q;

    logic                  req_acc;
    logic                  beat_acc;
    logic                  last_beat;
    logic [NUM_WAYS-1:0]   bank_en;
    logic                  bank_we;
    logic [IDX_W-1:0]      bank_idx;
    logic [WORD_W-1:0]     bank_word;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [NB-1:0]         bank_wstrb;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_WAYS];

    // A refill request wins over a CPU request in the same cycle.
    assign req_ready = (state_q == ST_IDLE) && !fill_start;
    assign req_acc   = req_valid && req_ready;
    assign beat_acc  = (state_q == ST_FILL) && fill_valid;
    assign last_beat = (beat_q == WORD_W'(WORDS_PER_LINE - 1));

    // CPU and refill never access the banks in the same cycle.
    always_comb begin
        bank_we    = req_we;
        bank_idx   = req_index;
        bank_word  = req_word;
        bank_wdata = req_wdata;
        bank_wstrb = req_wstrb;
        if (beat_acc) begin
            bank_we    = 1'b1;
            bank_idx   = fidx_q;
            bank_word  = beat_q;
            bank_wdata = fill_data;
            bank_wstrb = '1;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign bank_en[w] = (req_acc  && (req_way == WAY_W'(w))) ||
                            (beat_acc && (fway_q  == WAY_W'(w)));

        way_bank #(
            .DATA_WIDTH    (DATA_WIDTH),
            .WORDS_PER_LINE(WORDS_PER_LINE),
            .NUM_SETS      (NUM_SETS)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bank_en[w]),
            .we     (bank_we),
            .capture(req_acc),
            .index  (bank_idx),
            .word   (bank_word),
            .wdata  (bank_wdata),
            .wstrb  (bank_wstrb),
            .rdata  (bank_rdata[w])
        );
    end

    // Every bank read word is a flop and sel_q is registered, so this holds.
    assign rsp_rdata = bank_rdata[sel_q];

    // Refill FSM and response bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            fway_q    <= '0;
            fidx_q    <= '0;
            sel_q     <= '0;
            rsp_valid <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            rsp_valid <= req_acc;
            fill_done <= 1'b0;
            if (req_acc) sel_q <= req_way;
            case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        state_q   <= ST_FILL;
                        fill_busy <= 1'b1;
                        fway_q    <= fill_way;
                        fidx_q    <= fill_index;
                        beat_q    <= '0;
                    end
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        if (last_beat) begin
                            state_q   <= ST_IDLE;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                            beat_q    <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
